// File: rtl/scma_host_pkg.sv
// Shared types and default sizes for SCMA host-side blocks.
// State encoding, bus widths and the wait counter width.
package scma_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_LAT,
        ST_RSP
    } state_e;

    localparam int DEF_DATA_IN_WIDTH  = 36;
    localparam int DEF_DATA_OUT_WIDTH = 32;
    localparam int DEF_ADDR_IN_WIDTH  = 11;
    localparam int DEF_CHIP_EN_NUM    = 16;
    localparam int DEF_CHIP_IDX_WIDTH = 4;
    localparam int DEF_RD_LAT         = 2;
    localparam int DEF_TIMEOUT        = 255;

    localparam int CNT_W = 8;

endpackage

// File: rtl/scma_host_master_if.sv
// Request/response and array-bus bundle of the SCMA host master.
// master: the host master itself; slave: the host plus array side.
interface scma_host_master_if
    import scma_host_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int ADDR_IN_WIDTH  = DEF_ADDR_IN_WIDTH,
    parameter int CHIP_EN_NUM    = DEF_CHIP_EN_NUM,
    parameter int CHIP_IDX_WIDTH = DEF_CHIP_IDX_WIDTH
);

    logic                                   req_valid;
    logic                                   req_ready;
    logic                                   req_write;
    logic                                   req_bcast;
    logic [CHIP_IDX_WIDTH-1:0]              req_chip;
    logic [ADDR_IN_WIDTH-1:0]               req_addr;
    logic [DATA_IN_WIDTH-1:0]               req_wdata;
    logic                                   rsp_valid;
    logic [DATA_OUT_WIDTH-1:0]              rsp_data;
    logic                                   rsp_err;
    logic [ADDR_IN_WIDTH+CHIP_EN_NUM-1:0]   a_in;
    logic [DATA_IN_WIDTH-1:0]               data_in;
    logic [DATA_OUT_WIDTH-1:0]              data_out;
    logic                                   empty;
    logic                                   full;

    modport master (
        input  req_valid, req_write, req_bcast,
        input  req_chip, req_addr, req_wdata,
        input  data_out, empty, full,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output a_in, data_in
    );

    modport slave (
        output req_valid, req_write, req_bcast,
        output req_chip, req_addr, req_wdata,
        output data_out, empty, full,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  a_in, data_in
    );

endinterface

// File: rtl/scma_chip_sel_dec.sv
// Chip index to one-hot select decoder with broadcast override.
module scma_chip_sel_dec #(
    parameter int CHIP_EN_NUM    = 16,
    parameter int CHIP_IDX_WIDTH = 4
) (
    input  logic [CHIP_IDX_WIDTH-1:0] idx_i,
    input  logic                      bcast_i,
    output logic [CHIP_EN_NUM-1:0]    sel_o
);

    always_comb begin
        sel_o = '0;
        unique case (1'b1)
            bcast_i: sel_o = '1;
            default: sel_o[idx_i] = 1'b1;
        endcase
    end

endmodule

// File: rtl/scma_host_master.sv
// Single-outstanding host initiator for the SCMA array port.
// Define SCMA_HOST_STATS_EN to add write/read/timeout counters.
module scma_host_master
    import scma_host_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int ADDR_IN_WIDTH  = DEF_ADDR_IN_WIDTH,
    parameter int CHIP_EN_NUM    = DEF_CHIP_EN_NUM,
    parameter int CHIP_IDX_WIDTH = DEF_CHIP_IDX_WIDTH,
    parameter int RD_LAT         = DEF_RD_LAT,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    scma_host_master_if.master bus
`ifdef SCMA_HOST_STATS_EN
    ,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_to_cnt
`endif
);

    localparam int AW = ADDR_IN_WIDTH + CHIP_EN_NUM;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(RD_LAT);

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [AW-1:0]             a_in_q;
    logic [DATA_IN_WIDTH-1:0]  data_in_q;
    logic                      ready_q;
    logic                      rsp_valid_q;
    logic                      rsp_err_q;
    logic [DATA_OUT_WIDTH-1:0] rsp_data_q;

    logic [CHIP_EN_NUM-1:0]    sel_d;
    logic [CNT_W-1:0]          cnt_inc_d;
    logic                      accept_d;
    logic                      illegal_d;
    logic                      wr_done_d;
    logic                      rd_done_d;
    logic                      to_d;

    scma_chip_sel_dec #(
        .CHIP_EN_NUM    (CHIP_EN_NUM),
        .CHIP_IDX_WIDTH (CHIP_IDX_WIDTH)
    ) u_sel_dec (
        .idx_i   (bus.req_chip),
        .bcast_i (bus.req_bcast),
        .sel_o   (sel_d)
    );

    assign accept_d  = bus.req_valid & ready_q;
    assign illegal_d = ~bus.req_write & bus.req_bcast;
    assign cnt_inc_d = cnt_q + CNT_W'(1);

    assign wr_done_d = (state_q == ST_WR) && !bus.full;
    assign rd_done_d = (state_q == ST_RD_LAT) && (cnt_q == LAT_VAL);
    // The counter never passes TIMEOUT: the stall that reaches it ends the wait.
    assign to_d = (((state_q == ST_WR) && bus.full) ||
                   ((state_q == ST_RD_WAIT) && bus.empty)) &&
                  (cnt_inc_d == TO_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_in_q      <= '0;
            data_in_q   <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                    if (accept_d) begin
                        ready_q <= 1'b0;
                        if (illegal_d) begin
                            state_q <= ST_RSP;
                        end else begin
                            a_in_q    <= {sel_d, bus.req_addr};
                            data_in_q <= bus.req_write ? bus.req_wdata : '0;
                            state_q   <= bus.req_write ? ST_WR : ST_RD_WAIT;
                        end
                    end
                end
                ST_WR, ST_RD_WAIT, ST_RD_LAT: begin
                    if (wr_done_d || rd_done_d || to_d) begin
                        state_q     <= ST_RSP;
                        a_in_q      <= '0;
                        data_in_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= to_d;
                        if (rd_done_d) begin
                            rsp_data_q <= bus.data_out;
                        end
                    end else if ((state_q == ST_RD_WAIT) && !bus.empty) begin
                        state_q <= ST_RD_LAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_RSP: begin
                    // Entering with no strobe means an illegal request: raise it now.
                    if (rsp_valid_q) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.a_in      = a_in_q;
    assign bus.data_in   = data_in_q;

`ifdef SCMA_HOST_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;
    logic [15:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            if (wr_done_d) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd_done_d) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (to_d)      to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign stat_wr_cnt = wr_cnt_q;
    assign stat_rd_cnt = rd_cnt_q;
    assign stat_to_cnt = to_cnt_q;
`endif

endmodule

// File: tb/tb_scma_host_master.sv
// Directed plus randomized bench for scma_host_master against a
// latency/response model derived from the request and stall lengths.
module tb_scma_host_master;

    localparam int DIW = 36;
    localparam int DOW = 32;
    localparam int AIW = 11;
    localparam int CEN = 16;
    localparam int CIW = 4;
    localparam int RDL = 2;
    localparam int TMO = 255;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_wr = 0;
    int   exp_rd = 0;
    int   exp_to = 0;

    scma_host_master_if #(
        .DATA_IN_WIDTH  (DIW),
        .DATA_OUT_WIDTH (DOW),
        .ADDR_IN_WIDTH  (AIW),
        .CHIP_EN_NUM    (CEN),
        .CHIP_IDX_WIDTH (CIW)
    ) bus ();

`ifdef SCMA_HOST_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_to_cnt;
`endif

    scma_host_master #(
        .DATA_IN_WIDTH  (DIW),
        .DATA_OUT_WIDTH (DOW),
        .ADDR_IN_WIDTH  (AIW),
        .CHIP_EN_NUM    (CEN),
        .CHIP_IDX_WIDTH (CIW),
        .RD_LAT         (RDL),
        .TIMEOUT        (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SCMA_HOST_STATS_EN
        ,
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt),
        .stat_to_cnt (stat_to_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef SCMA_HOST_STATS_EN
        chk({tag, "_swr"}, 64'(stat_wr_cnt), 64'(exp_wr % 65536));
        chk({tag, "_srd"}, 64'(stat_rd_cnt), 64'(exp_rd % 65536));
        chk({tag, "_sto"}, 64'(stat_to_cnt), 64'(exp_to % 65536));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // stall = full cycles for a write, empty-high cycles for a read.
    task automatic run_txn(input string tag, input bit wr, input bit bc,
                           input logic [CIW-1:0] chip,
                           input logic [AIW-1:0] addr,
                           input logic [DIW-1:0] wd, input int stall,
                           input logic [DOW-1:0] dout);
        bit                  ill;
        int                  exp_rsp;
        bit                  exp_err;
        logic [DOW-1:0]      exp_data;
        logic [CEN-1:0]      sel;
        logic [AIW+CEN-1:0]  exp_a;
        logic [DIW-1:0]      exp_d;
        int                  n;
        int                  rsp_cyc;
        int                  nrsp;
        int                  bus_bad;
        logic                err_seen;
        logic [DOW-1:0]      data_seen;

        ill = !wr && bc;
        exp_data = '0;
        exp_err  = 1'b0;
        if (ill) begin
            exp_rsp = 2;
            exp_err = 1'b1;
        end else if (stall >= TMO) begin
            exp_rsp = TMO + 1;
            exp_err = 1'b1;
            exp_to++;
        end else if (wr) begin
            exp_rsp = 2 + stall;
            exp_wr++;
        end else begin
            exp_rsp  = 3 + stall + RDL;
            exp_data = dout;
            exp_rd++;
        end
        sel = '0;
        if (bc) sel = '1;
        else sel[chip] = 1'b1;
        exp_a = ill ? '0 : {sel, addr};
        exp_d = wr ? wd : '0;

        n = 0;
        while (!bus.req_ready && n < 50) begin
            cyc();
            n++;
        end
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_bcast = bc;
        bus.req_chip  = chip;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.data_out  = dout;
        bus.full      = wr && stall > 0;
        bus.empty     = !wr && stall > 0;
        cyc();
        bus.req_valid = 1'b0;
        bus.req_chip  = CIW'($urandom);
        bus.req_addr  = AIW'($urandom);
        bus.req_wdata = {4'($urandom), 32'($urandom)};

        rsp_cyc   = -1;
        nrsp      = 0;
        bus_bad   = 0;
        err_seen  = 1'b0;
        data_seen = '0;
        for (int k = 1; k <= exp_rsp + 1; k++) begin
            bus.full  = wr && (k <= stall);
            bus.empty = !wr && (k <= stall);
            if (bus.rsp_valid === 1'b1) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc   = k;
                    err_seen  = bus.rsp_err;
                    data_seen = bus.rsp_data;
                end
                nrsp++;
            end
            if (k < exp_rsp) begin
                if (bus.a_in !== exp_a) bus_bad++;
                if (bus.data_in !== exp_d) bus_bad++;
                if (bus.req_ready !== 1'b0) bus_bad++;
            end else begin
                if (bus.a_in !== '0) bus_bad++;
                if (bus.data_in !== '0) bus_bad++;
            end
            if (k <= exp_rsp) cyc();
        end
        chk({tag, "_rspcyc"}, 64'(rsp_cyc), 64'(exp_rsp));
        chk({tag, "_nrsp"}, 64'(nrsp), 64'd1);
        chk({tag, "_err"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_data"}, 64'(data_seen), 64'(exp_data));
        chk({tag, "_bus"}, 64'(bus_bad), 64'd0);
        chk({tag, "_idle"}, 64'(bus.req_ready), 64'd1);
        chk_stats(tag);
        bus.full  = 1'b0;
        bus.empty = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bcast = 1'b0;
        bus.req_chip  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.data_out  = '0;
        bus.empty     = 1'b1;
        bus.full      = 1'b0;
        repeat (3) cyc();
        chk("rst_a_in", 64'(bus.a_in), 64'd0);
        chk("rst_data_in", 64'(bus.data_in), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 64'd0);
        chk_stats("rst");
        rst = 1'b1;
        #1;
        chk("rel_ready", 64'(bus.req_ready), 64'd0);
        cyc();
        chk("post_ready", 64'(bus.req_ready), 64'd1);

        run_txn("wr3", 1, 0, 4'd3, 11'h05A, 36'h123456789, 0, 32'h0);
        run_txn("rd15", 0, 0, 4'd15, 11'h7FF, 36'h0, 4, 32'hDEADBEEF);
        run_txn("bcwr", 1, 1, 4'd6, 11'h100, 36'hABCDEF012, 10, 32'h0);
        run_txn("rdto", 0, 0, 4'd0, 11'h001, 36'h0, 300, 32'h55AA55AA);
        run_txn("ill", 0, 1, 4'd2, 11'h222, 36'h0, 0, 32'h12345678);
        run_txn("wr254", 1, 0, 4'd9, 11'h3C3, 36'hF0F0F0F0F, 254, 32'h0);
        run_txn("wrto", 1, 0, 4'd12, 11'h0AB, 36'h0000FFFF1, 255, 32'h0);
        run_txn("rd254", 0, 0, 4'd7, 11'h444, 36'h0, 254, 32'hCAFEF00D);

        // Reset while the read is in its latency phase.
        while (!bus.req_ready) cyc();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_bcast = 1'b0;
        bus.req_chip  = 4'd5;
        bus.req_addr  = 11'h155;
        bus.empty     = 1'b0;
        bus.data_out  = 32'h0BADF00D;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        chk("rl_sel", 64'(bus.a_in), 64'({16'h0020, 11'h155}));
        rst = 1'b0;
        #1;
        chk("rl_a_in", 64'(bus.a_in), 64'd0);
        chk("rl_rsp", 64'(bus.rsp_valid), 64'd0);
        repeat (2) cyc();
        chk("rl_hold", {bus.rsp_valid, bus.a_in}, 64'd0);
        exp_wr = 0;
        exp_rd = 0;
        exp_to = 0;
        chk_stats("rl");
        rst = 1'b1;
        bus.empty = 1'b1;
        cyc();
        run_txn("wr1", 1, 0, 4'd1, 11'h011, 36'h876543210, 0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            bit             w;
            bit             b;
            int             st;
            string          t;
            w  = 1'($urandom);
            b  = ($urandom_range(0, 5) == 0);
            st = $urandom_range(0, 12);
            if (i == 10) st = TMO;
            t = $sformatf("rnd%0d", i);
            run_txn(t, w, b, CIW'($urandom), AIW'($urandom),
                    {4'($urandom), 32'($urandom)}, st, 32'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scma_host_master.md
Name: scma_host_master

Overview:
Host-side initiator for the SCMA array port. It turns single read/write requests on a valid/ready interface into the array's address/chip-select/data bus (a_in, data_in). It observes the array's data_out, empty and full, and returns read data or a timeout error on a one-cycle response strobe. It sits between the host controller and the SCMA array top.

Parameters:
- DATA_IN_WIDTH, 36, width of write data driven to the array
- DATA_OUT_WIDTH, 32, width of read data returned by the array
- ADDR_IN_WIDTH, 11, per-chip address width
- CHIP_EN_NUM, 16, number of chips; width of the one-hot chip-select field
- CHIP_IDX_WIDTH, 4, log2(CHIP_EN_NUM)
- RD_LAT, 2, cycles between read select valid (empty low) and data_out capture; legal range 1..7
- TIMEOUT, 255, maximum wait cycles on full (write) or empty (read) before error

Ports:
- clk, input, 1, single clock
- rst, input, 1, asynchronous active-low reset
- req_valid, input, 1, request present
- req_ready, output, 1, request accepted when high with req_valid
- req_write, input, 1, 1 = write, 0 = read
- req_bcast, input, 1, write to all chips (write only)
- req_chip, input, CHIP_IDX_WIDTH, target chip index
- req_addr, input, ADDR_IN_WIDTH, target address
- req_wdata, input, DATA_IN_WIDTH, write data
- rsp_valid, output, 1, one-cycle response strobe
- rsp_data, output, DATA_OUT_WIDTH, read data; 0 for writes and errors
- rsp_err, output, 1, qualified by rsp_valid: timeout or illegal request
- a_in, output, ADDR_IN_WIDTH+CHIP_EN_NUM, {one-hot chip select, address}
- data_in, output, DATA_IN_WIDTH, write data to the array
- data_out, input, DATA_OUT_WIDTH, read data from the array
- empty, input, 1, selected chips have no data
- full, input, 1, any selected chip is full

Behaviour:
- One clock domain; reset is asynchronous and active-low on rst. In reset: state IDLE, a_in=0, data_in=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, wait counter 0.
- req_ready = 1 only in IDLE and not in the reset-release cycle. Exactly one request is outstanding.
- Request capture: on acceptance, chip, address, data and type are registered. The one-hot select is the decode of req_chip, or all ones if req_bcast. a_in and data_in come only from registers, never combinationally from req_*.
- States:
  - IDLE: select field 0.
  - WR: drive the select, address and data. A cycle with full=0 completes the write. Go to RSP with err=0. Each full=1 cycle increments the counter; when the counter reaches TIMEOUT, go to RSP with err=1.
  - RD_WAIT: drive the select and address. On empty=0, reset the counter and go to RD_LAT. The timeout rule is the same as in WR.
  - RD_LAT: hold the select for RD_LAT cycles, then capture data_out into rsp_data. Go to RSP.
  - RSP: rsp_valid=1 for exactly one cycle, select cleared, then go to IDLE.
- Write latency with no stall: accept at cycle 0, select on a_in in cycle 1, rsp_valid in cycle 2.
- Read latency with empty already low: rsp_valid at accept + 3 + RD_LAT.
- Illegal request (read with req_bcast=1): no bus activity; go directly to RSP with rsp_err=1, rsp_data=0.
- The select is cleared in every cycle outside WR, RD_WAIT and RD_LAT, so no chip is left selected.
- Counter saturates at TIMEOUT; its width is 8 bits.
- Reset asserted mid-transaction aborts it immediately: select cleared asynchronously, no response issued.

Optional Feature:
- Macro SCMA_HOST_STATS_EN.
- Defined: adds output ports stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_to_cnt[15:0]. These count successful writes, successful reads and timeouts. They wrap modulo 2^16 and clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package scma_host_pkg holds:
  - state enum (IDLE, WR, RD_WAIT, RD_LAT, RSP)
  - default width constants
  - timeout counter width
- Sub-module scma_chip_sel_dec: combinational index-plus-broadcast to one-hot decoder, also used by future host blocks.

Test Plan:
- Write chip 3, addr 0x05A, data 0x123456789, full=0 -> a_in = {16'h0008, 11'h05A} for one cycle, data_in = 0x123456789; rsp_valid 2 cycles after accept, rsp_err=0.
- Read chip 15, addr 0x7FF; empty low after 4 cycles; data_out=0xDEADBEEF; RD_LAT=2 -> rsp_data=0xDEADBEEF, rsp_err=0; select 16'h8000 held throughout.
- Broadcast write with full held high 10 cycles -> a_in select = 16'hFFFF for 11 cycles; write completes on the first full=0 cycle; rsp_err=0.
- Read chip 0 with empty stuck high, TIMEOUT=255 -> rsp_valid with rsp_err=1 after 255 wait cycles; rsp_data=0; select cleared next cycle.
- Read request with req_bcast=1 -> no select asserted; rsp_valid two cycles after accept with rsp_err=1.
- Assert rst low during RD_LAT -> a_in=0 and rsp_valid=0 immediately; after release, a new write to chip 1 completes normally.
